output_buffer: RTL and testbench

- Sits directly downstream of the Accumulator.
- Captures each stored 32-bit result (output_data / output_buffer_addr / output_buffer_enable) into an addressed entry. On command, drains all valid entries in ascending address order over a valid/ready stream to the memory/host side.
- Tracks occupancy and flags overwrite of an undrained entry.

---
 rtl/output_buffer_pkg.sv | 26 ++
 rtl/output_buffer_if.sv | 24 ++
 rtl/output_buffer_mem.sv | 33 +++
 rtl/output_buffer.sv | 159 +++++++++++++++
 tb/tb_output_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/output_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : output_buffer_pkg
//  Purpose  : Shared types and default sizes for the accumulator output buffer
//  Revision : 1.0 - initial release
// ============================================================================
package output_buffer_pkg;

  // bfp32 word width, common to the accumulator and bfp32_adder
  localparam int c_BFP32_W = 32;

  // Default buffer geometry; DEPTH must equal 2**ADDR_W
  localparam int c_ADDR_W = 4;
  localparam int c_DEPTH  = 16;
  localparam int c_DATA_W = c_BFP32_W;

  // Drain sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } obuf_state_e;

endpackage
`default_nettype wire

// File: rtl/output_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : output_buffer_if
//  Purpose  : valid/ready stream carrying drained entries (data + entry index)
//  Revision : 1.0 - initial release
// ============================================================================
interface output_buffer_if
  import output_buffer_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;

  // Buffer side drives the word, consumer side drives the accept
  modport master (output m_valid, output m_data, output m_addr, input m_ready);
  modport slave  (input m_valid, input m_data, input m_addr, output m_ready);

endinterface
`default_nettype wire

// File: rtl/output_buffer_mem.sv
`default_nettype none
// ============================================================================
//  Module   : obuf_mem
//  Purpose  : DEPTH x DATA_W register array, one write port, one async read
//  Revision : 1.0 - initial release
// ============================================================================
module obuf_mem
  import output_buffer_pkg::*;
#(
  parameter int DEPTH  = c_DEPTH,
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
) (
  input  wire logic              clk,
  input  wire logic              wr_en,
  input  wire logic [ADDR_W-1:0] wr_addr,
  input  wire logic [DATA_W-1:0] wr_data,
  input  wire logic [ADDR_W-1:0] rd_addr,
  output logic      [DATA_W-1:0] rd_data
);

  // Storage is deliberately not reset; validity is tracked by the owner
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Single write port
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/output_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : output_buffer
//  Purpose  : Captures accumulator results into addressed entries and drains
//             valid entries in ascending address order over a stream
//  Revision : 1.0 - initial release
// ============================================================================
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int DEPTH  = c_DEPTH,
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
) (
  input  wire logic              clk,
  input  wire logic              rst,          // asynchronous, active-low
  input  wire logic              wr_en,
  input  wire logic [ADDR_W-1:0] wr_addr,
  input  wire logic [DATA_W-1:0] wr_data,
  input  wire logic              drain_start,
  output_buffer_if.master        m,
  output logic                   busy,
  output logic                   done,
  output logic      [ADDR_W:0]   occupancy,
  output logic                   overwrite_err,
  input  wire logic              err_clear
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

  obuf_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              w_load;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W:0]   r_occ;
  logic              r_err;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] w_rd_data;

  logic w_retire, w_hit_ptr, w_inc, w_dec, w_overwrite;

  // A handshake retiring the entry that is being rewritten in the same cycle
  // leaves it valid with the new data, so it is neither an error nor a count change.
  assign w_retire    = (r_state == SEND) && m.m_ready;
  assign w_hit_ptr   = wr_en && (wr_addr == r_ptr);
  assign w_inc       = wr_en && !r_valid[wr_addr];
  assign w_dec       = w_retire && !w_hit_ptr;
  assign w_overwrite = wr_en && r_valid[wr_addr] && !(w_retire && w_hit_ptr);

  obuf_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (r_ptr),
    .rd_data (w_rd_data)
  );

  // Drain sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state: scan one entry per cycle, hold in SEND until accepted
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (drain_start) begin
          w_ptr_nxt   = '0;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (r_valid[r_ptr]) begin
          w_load      = 1'b1;
          w_state_nxt = SEND;
        end else if (r_ptr == c_LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_ptr_nxt   = r_ptr + 1'b1;
        end
      end
      SEND: begin
        if (m.m_ready) begin
          if (r_ptr == c_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_ptr_nxt   = r_ptr + 1'b1;
            w_state_nxt = SCAN;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output word snapshot taken in SCAN so later writes cannot disturb it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_addr  <= '0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_rd_data;
      r_m_addr  <= r_ptr;
    end else if (w_retire) begin
      r_m_valid <= 1'b0;
    end
  end

  // Entry valid flags: a write takes priority over a retire of the same entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else begin
      if (w_retire) r_valid[r_ptr]   <= 1'b0;
      if (wr_en)    r_valid[wr_addr] <= 1'b1;
    end
  end

  // Occupancy count and sticky overwrite flag (a new overwrite beats a clear)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= '0;
      r_err <= 1'b0;
    end else begin
      r_occ <= r_occ + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
      if (w_overwrite)    r_err <= 1'b1;
      else if (err_clear) r_err <= 1'b0;
    end
  end

  assign m.m_valid     = r_m_valid;
  assign m.m_data      = r_m_data;
  assign m.m_addr      = r_m_addr;
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);
  assign occupancy     = r_occ;
  assign overwrite_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_output_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_output_buffer
//  Purpose  : Self-checking bench for output_buffer with an array-based model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_output_buffer;
  import output_buffer_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              drain_start = 1'b0;
  logic              err_clear = 1'b0;
  logic              busy, done, overwrite_err;
  logic [ADDR_W:0]   occupancy;

  output_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

  output_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .drain_start   (drain_start),
    .m             (sif.master),
    .busy          (busy),
    .done          (done),
    .occupancy     (occupancy),
    .overwrite_err (overwrite_err),
    .err_clear     (err_clear)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain arrays of entry contents and validity
  logic [DATA_W-1:0] mdl_mem   [DEPTH];
  bit                mdl_valid [DEPTH];
  bit                mdl_err;

  int                got_addr [$];
  logic [DATA_W-1:0] got_data [$];
  int                exp_addr [$];
  logic [DATA_W-1:0] exp_data [$];

  function automatic void mdl_reset();
    for (int i = 0; i < DEPTH; i++) mdl_valid[i] = 1'b0;
    mdl_err = 1'b0;
  endfunction

  function automatic int mdl_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mdl_valid[i]) n++;
    return n;
  endfunction

  function automatic void mdl_write(input int a, input logic [DATA_W-1:0] d);
    if (mdl_valid[a]) mdl_err = 1'b1;
    mdl_valid[a] = 1'b1;
    mdl_mem[a]   = d;
  endfunction

  // A full drain delivers every valid entry in ascending order and empties the buffer
  function automatic void mdl_expect();
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (mdl_valid[i]) begin
        exp_addr.push_back(i);
        exp_data.push_back(mdl_mem[i]);
        mdl_valid[i] = 1'b0;
      end
    end
  endfunction

  // All stimulus tasks start and end on a falling edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; drain_start = 1'b0; err_clear = 1'b0; sif.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mdl_reset();
  endtask

  task automatic write_entry(input int a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mdl_write(a, d);
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Issues drain_start and records the words accepted; latencies are in cycles
  task automatic run_drain(input int ready_pct, output int first_lat, output int done_lat,
                           output int done_pulses, output int busy_cycles);
    got_addr.delete();
    got_data.delete();
    first_lat = -1; done_lat = -1; done_pulses = 0; busy_cycles = 0;
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    for (int cyc = 1; cyc <= DEPTH * 16; cyc++) begin
      if (busy) busy_cycles++;
      if (sif.m_valid && first_lat < 0) first_lat = cyc;
      if (done) begin
        done_pulses++;
        if (done_lat < 0) done_lat = cyc;
      end
      if (sif.m_valid) begin
        sif.m_ready = (int'($urandom_range(99)) < ready_pct);
        if (sif.m_ready) begin
          got_addr.push_back(int'(sif.m_addr));
          got_data.push_back(sif.m_data);
        end
      end else begin
        sif.m_ready = 1'($urandom_range(1));
      end
      @(negedge clk);
      if (done_lat >= 0 && cyc >= done_lat + 2) break;
    end
    sif.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sif.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", sif.m_valid); end
    checks++; if (sif.m_data !== '0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", sif.m_data); end
    checks++; if (sif.m_addr !== '0) begin failures++; $display("FAIL reset_m_addr got=%0d exp=0", sif.m_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (occupancy !== '0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (overwrite_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", overwrite_err); end
  endtask

  task automatic test_two_words();
    int fl, dl, dp, bc;
    do_reset();
    write_entry(2, 32'h3F80_0000);
    write_entry(9, 32'h4000_0000);
    checks++; if (occupancy !== 5'd2) begin failures++; $display("FAIL two_occ_before got=%0d exp=2", occupancy); end
    mdl_expect();
    run_drain(100, fl, dl, dp, bc);
    checks++; if (fl != 4) begin failures++; $display("FAIL two_first_latency got=%0d exp=4", fl); end
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      failures++; $display("FAIL two_word_count got=%0d exp=%0d", got_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        checks++;
        if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
          failures++;
          $display("FAIL two_word%0d got=%0d:%h exp=%0d:%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    checks++; if (dp != 1) begin failures++; $display("FAIL two_done_pulses got=%0d exp=1", dp); end
    checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL two_occ_after got=%0d exp=0", occupancy); end
  endtask

  task automatic test_empty();
    int fl, dl, dp, bc;
    do_reset();
    run_drain(100, fl, dl, dp, bc);
    checks++; if (got_addr.size() != 0) begin failures++; $display("FAIL empty_words got=%0d exp=0", got_addr.size()); end
    checks++; if (fl != -1) begin failures++; $display("FAIL empty_m_valid first_at=%0d exp=never", fl); end
    checks++; if (dl != DEPTH + 1) begin failures++; $display("FAIL empty_done_latency got=%0d exp=%0d", dl, DEPTH + 1); end
    checks++; if (dp != 1) begin failures++; $display("FAIL empty_done_pulses got=%0d exp=1", dp); end
    checks++; if (bc != DEPTH + 1) begin failures++; $display("FAIL empty_busy_cycles got=%0d exp=%0d", bc, DEPTH + 1); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d;
    bit ok;
    do_reset();
    d = $urandom;
    write_entry(0, d);
    sif.m_ready = 1'b0;
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sif.m_valid !== 1'b1 || sif.m_data !== d || sif.m_addr !== '0) begin
        failures++;
        $display("FAIL stall_hold%0d got=%b/%h/%0d exp=1/%h/0", i, sif.m_valid, sif.m_data, sif.m_addr, d);
      end
      @(negedge clk);
    end
    checks++; if (sif.m_valid !== 1'b1) begin failures++; $display("FAIL stall_still_valid got=%b exp=1", sif.m_valid); end
    sif.m_ready = 1'b1;
    @(negedge clk);
    sif.m_ready = 1'b0;
    checks++; if (sif.m_valid !== 1'b0) begin failures++; $display("FAIL stall_retire_valid got=%b exp=0", sif.m_valid); end
    checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL stall_retire_occ got=%0d exp=0", occupancy); end
    mdl_reset();
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_idle_timeout busy=%b exp=0", busy); end
  endtask

  task automatic test_overwrite();
    int fl, dl, dp, bc;
    do_reset();
    write_entry(5, 32'h1);
    write_entry(5, 32'h1);
    checks++; if (overwrite_err !== 1'b1) begin failures++; $display("FAIL ovw_flag got=%b exp=1", overwrite_err); end
    checks++; if (occupancy !== 5'd1) begin failures++; $display("FAIL ovw_occ got=%0d exp=1", occupancy); end
    // clear and a fresh overwrite together must leave the flag set
    err_clear = 1'b1;
    write_entry(5, 32'h1);
    err_clear = 1'b0;
    checks++; if (overwrite_err !== 1'b1) begin failures++; $display("FAIL ovw_clear_collide got=%b exp=1", overwrite_err); end
    mdl_expect();
    run_drain(100, fl, dl, dp, bc);
    checks++;
    if (got_addr.size() != 1 || got_addr[0] != 5 || got_data[0] !== 32'h1) begin
      failures++; $display("FAIL ovw_drain got_count=%0d exp=1 word addr5=00000001", got_addr.size());
    end
    pulse_err_clear();
    checks++; if (overwrite_err !== 1'b0) begin failures++; $display("FAIL ovw_cleared got=%b exp=0", overwrite_err); end
  endtask

  task automatic test_write_on_handshake();
    int fl, dl, dp, bc;
    bit seen, ok;
    do_reset();
    write_entry(4, 32'h11);
    sif.m_ready = 1'b0;
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sif.m_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL hs_wait_valid got=timeout exp=m_valid"); end
    checks++;
    if (sif.m_addr !== 4'd4 || sif.m_data !== 32'h11) begin
      failures++; $display("FAIL hs_word got=%0d:%h exp=4:00000011", sif.m_addr, sif.m_data);
    end
    sif.m_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h0000_ABCD;
    @(negedge clk);
    wr_en = 1'b0; sif.m_ready = 1'b0;
    mdl_reset();
    mdl_write(4, 32'h0000_ABCD);
    checks++; if (overwrite_err !== 1'b0) begin failures++; $display("FAIL hs_no_error got=%b exp=0", overwrite_err); end
    checks++; if (occupancy !== 5'd1) begin failures++; $display("FAIL hs_occ got=%0d exp=1", occupancy); end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL hs_idle_timeout busy=%b exp=0", busy); end
    mdl_expect();
    run_drain(100, fl, dl, dp, bc);
    checks++;
    if (got_addr.size() != 1 || got_addr[0] != 4 || got_data[0] !== 32'h0000_ABCD) begin
      failures++; $display("FAIL hs_redrain got_count=%0d exp=1 word addr4=0000abcd", got_addr.size());
    end
  endtask

  task automatic test_async_reset();
    int fl, dl, dp, bc;
    bit seen;
    do_reset();
    write_entry(3, $urandom);
    write_entry(7, $urandom);
    sif.m_ready = 1'b0;
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sif.m_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL areset_wait_valid got=timeout exp=m_valid"); end
    #2 rst = 1'b0;
    #1;
    checks++; if (sif.m_valid !== 1'b0) begin failures++; $display("FAIL areset_m_valid got=%b exp=0", sif.m_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
    checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL areset_occ got=%0d exp=0", occupancy); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL areset_done got=%b exp=0", done); end
    rst = 1'b1;
    mdl_reset();
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL areset_done_after got=%b exp=0", done); end
    run_drain(100, fl, dl, dp, bc);
    checks++; if (got_addr.size() != 0) begin failures++; $display("FAIL areset_redrain got=%0d exp=0", got_addr.size()); end
    checks++; if (dl != DEPTH + 1) begin failures++; $display("FAIL areset_done_latency got=%0d exp=%0d", dl, DEPTH + 1); end
  endtask

  task automatic test_random();
    int fl, dl, dp, bc, n;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 20));
      for (int k = 0; k < n; k++) write_entry(int'($urandom_range(DEPTH - 1)), $urandom);
      checks++; if (occupancy !== (ADDR_W+1)'(mdl_count())) begin failures++; $display("FAIL rnd%0d_occ got=%0d exp=%0d", r, occupancy, mdl_count()); end
      checks++; if (overwrite_err !== mdl_err) begin failures++; $display("FAIL rnd%0d_err got=%b exp=%b", r, overwrite_err, mdl_err); end
      mdl_expect();
      run_drain(60, fl, dl, dp, bc);
      checks++;
      if (got_addr.size() != exp_addr.size()) begin
        failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", r, got_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          checks++;
          if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
            failures++;
            $display("FAIL rnd%0d_word%0d got=%0d:%h exp=%0d:%h", r, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
      checks++; if (dp != 1) begin failures++; $display("FAIL rnd%0d_done_pulses got=%0d exp=1", r, dp); end
      checks++; if (occupancy !== '0) begin failures++; $display("FAIL rnd%0d_occ_after got=%0d exp=0", r, occupancy); end
      pulse_err_clear();
      mdl_err = 1'b0;
      checks++; if (overwrite_err !== 1'b0) begin failures++; $display("FAIL rnd%0d_err_clear got=%b exp=0", r, overwrite_err); end
    end
  endtask

  initial begin
    sif.m_ready = 1'b0;
    test_reset();
    test_two_words();
    test_empty();
    test_backpressure();
    test_overwrite();
    test_write_on_handshake();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
`default_nettype wire
